// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned MEMORY_BITS_DFLT = 11;
  localparam int unsigned MEMORY_SIZE_DFLT = 2048;
  localparam int unsigned HDR_BITS         = 16;
  localparam int unsigned BYTE_BITS        = 8;
  localparam int unsigned WORD_BITS        = 32;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid marks the 4th byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [BYTE_BITS-1:0] byte_in,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  localparam int unsigned SR_BITS = WORD_BITS - BYTE_BITS;

  logic [SR_BITS-1:0] sr_q;
  logic [1:0]         idx_q;

  assign word_valid = shift_en && (idx_q == 2'd3);
  assign word       = {sr_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (clear) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (shift_en) begin
      sr_q  <= {sr_q[SR_BITS-BYTE_BITS-1:0], byte_in};
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEMORY_BITS = MEMORY_BITS_DFLT,
  parameter int unsigned MEMORY_SIZE = MEMORY_SIZE_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   in_valid,
  input  logic [BYTE_BITS-1:0]   in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [MEMORY_BITS-1:0] wr_addr,
  output logic [WORD_BITS-1:0]   wr_data,
  output logic                   core_hold,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int unsigned IDX_BITS = MEMORY_BITS + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM;
  logic [BYTE_BITS-1:0] csum_q, csum_d;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t                 state_q, state_d;
  logic [HDR_BITS-1:0]    count_q, count_d, hdr_c;
  logic [IDX_BITS-1:0]    idx_q, idx_d, idx_inc;
  logic                   accept, pk_clear, pk_shift, pk_valid;
  logic [WORD_BITS-1:0]   pk_word;
  logic                   wr_en_d, in_ready_d, core_hold_d, load_done_d, load_err_d;
  logic [MEMORY_BITS-1:0] wr_addr_d;
  logic [WORD_BITS-1:0]   wr_data_d;

  assign accept   = in_valid && in_ready;
  assign hdr_c    = {count_q[HDR_BITS-1:BYTE_BITS], in_data};
  assign idx_inc  = idx_q + IDX_BITS'(1);
  assign pk_shift = accept && (state_q == ST_DATA);
  assign pk_clear = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (restart && ((state_q == ST_DONE) || (state_q == ST_ERR)));

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .shift_en   (pk_shift),
    .byte_in    (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Next-state, counters and output-register inputs
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          count_d = {in_data, count_q[BYTE_BITS-1:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d = hdr_c;
          idx_d   = '0;
          if (hdr_c == '0)
            state_d = ST_AFTER_DATA;
          else if ((HDR_BITS+1)'(hdr_c) > (HDR_BITS+1)'(MEMORY_SIZE))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (pk_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q[MEMORY_BITS-1:0];
            wr_data_d = pk_word;
            idx_d     = idx_inc;
            if (HDR_BITS'(idx_inc) == count_q)
              state_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept)
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d = ST_LEN_HI;
          count_d = '0;
          idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      default: state_d = ST_LEN_HI;
    endcase

    in_ready_d  = (state_d != ST_DONE) && (state_d != ST_ERR);
    core_hold_d = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LEN_HI;
      count_q   <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      in_ready  <= in_ready_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      core_hold <= core_hold_d;
      load_done <= load_done_d;
      load_err  <= load_err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory read by the fetch/decode stage. Accepts a byte stream (from the UART receiver or the bench), parses a 16-bit word-count header, packs bytes MSB-first into 32-bit instructions and issues one write per word at sequential addresses from 0. Holds the core in reset until the image is fully and correctly loaded.

## Interface
- MEMORY_BITS, 11, instruction memory address width
- MEMORY_SIZE, 2048, instruction memory depth in words; must equal 2**MEMORY_BITS
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  one-cycle pulse; re-arms the loader from DONE or ERR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  MEMORY_BITS  word address
- wr_data  out  32  instruction word
- core_hold  out  1  keeps the core in reset while high
- load_done  out  1  image loaded successfully
- load_err  out  1  header or checksum error

## Operation
- A byte transfers when in_valid && in_ready on a rising edge.
- States: LEN_HI, LEN_LO, DATA, DONE, ERR.
- LEN_HI: the accepted byte becomes count[15:8]; next state is LEN_LO.
- LEN_LO: the accepted byte becomes count[7:0]. Then:
  - count == 0: go to DONE.
  - count > MEMORY_SIZE: go to ERR.
  - otherwise: go to DATA with word address 0 and byte index 0.
- DATA: bytes shift into a 32-bit packer, first byte into [31:24].
  - On the 4th byte, wr_en pulses with wr_data = the packed word and wr_addr = the current word index.
  - The word index then increments and the byte index wraps to 0.
  - After word count-1 is written, go to DONE.
- DONE/ERR: in_ready=0; the state persists until restart or reset.
  - restart in DONE/ERR clears counters and the packer and returns to LEN_HI.
  - restart in any other state is ignored.
- in_ready = 1 in LEN_HI, LEN_LO and DATA; 0 in DONE and ERR.
- core_hold = 1 in every state except DONE; it stays high in ERR.
- load_done = (state == DONE); load_err = (state == ERR).
- Word index is MEMORY_BITS+1 bits wide so that count == MEMORY_SIZE terminates without aliasing. wr_addr carries its low MEMORY_BITS bits.

## Timing
- Reset values: state=LEN_HI, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, load_done=0, load_err=0. Counters and the packer are cleared.
- Write latency: wr_en, wr_addr and wr_data are registered and appear in the cycle after the edge that accepted the 4th byte.
- wr_data and wr_addr hold their values when wr_en=0.
- Back-to-back bytes are accepted every cycle; there are no bubbles between words.
- The final wr_en and the DONE transition fall on the same edge, so load_done rises together with the last write pulse.
- Reset asserted mid-load aborts immediately. No partial write is issued, and the memory contents written so far are left as-is.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all DATA bytes is kept.
  - After the last word the FSM enters an extra CSUM state with in_ready=1.
  - The next byte is compared with the running XOR: equal goes to DONE, mismatch goes to ERR.
  - A count == 0 image still expects a checksum byte, which must be 0x00.
- Undefined: no CSUM state and no XOR register; behaviour is exactly as in Operation.

## Structure
- Shared package: state encoding (LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR), MEMORY_SIZE/MEMORY_BITS defaults, header width constant (16).
- Sub-module imem_word_packer: byte shift register plus 2-bit byte index.
  - Outputs word_valid and word.
  - Has a clear input driven by restart and the header states.
- The FSM, the word counter and the output registers stay in imem_loader.

## Test plan
- Header 0x0002, bytes 20 08 00 05 / 00 00 00 00 -> wr_en at addr 0 data 0x20080005, then addr 1 data 0x00000000; load_done=1 and core_hold=0 on the second write.
- Header 0x0000 (checksum off) -> DONE after 2 bytes, no wr_en, in_ready=0.
- Header 0x0801 (2049 > 2048) -> load_err=1, core_hold=1, no writes; restart pulse -> LEN_HI with in_ready=1.
- Header 0x0800 with 8192 back-to-back bytes -> 2048 writes at addresses 0..2047 with no wrap to 0, then DONE.
- rst_n low after 2 data bytes -> outputs return to reset values and no wr_en occurs; a fresh image then loads correctly.
- IMEM_LOADER_CHECKSUM_EN, one word 11 22 33 44: trailing byte 0x44 -> DONE; trailing byte 0x45 -> ERR, with the word already written at addr 0.
